// File: rtl/osc_pkg.sv
// Shared types and constants for the ADC capture FIFO reader / UART sender.
package osc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      FETCH,
      LATCH,
      SEND,
      CSUM,
      DONE
   } state_t;

   localparam int UART_FRAME_BITS = 10;
   localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: baud down-counter with terminal-count compare plus a 10-bit shift register.
module uart_tx_byte
   import osc_pkg::*;
#(
   parameter int BIT_CYC = 217
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done,
   output logic       busy
);

   localparam int BAUD_W = $clog2(BIT_CYC + 1);
   localparam int BIT_W  = $clog2(UART_FRAME_BITS);

   logic [BAUD_W-1:0]          r_baud;
   logic [BIT_W-1:0]           r_bit;
   logic [UART_FRAME_BITS-1:0] r_shift;
   logic                       r_busy;
   logic                       w_bit_end;

   assign w_bit_end = (r_baud == '0);
   // done is combinational so the caller can react in the last stop-bit cycle
   assign done = r_busy && w_bit_end && (r_bit == BIT_W'(UART_FRAME_BITS - 1));
   assign tx   = r_busy ? r_shift[0] : 1'b1;
   assign busy = r_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '1;
         r_busy  <= 1'b0;
      end else if (load && !r_busy) begin
         r_shift <= {1'b1, data, 1'b0};
         r_baud  <= BAUD_W'(BIT_CYC - 1);
         r_bit   <= '0;
         r_busy  <= 1'b1;
      end else if (r_busy) begin
         if (w_bit_end) begin
            if (done) begin
               r_busy <= 1'b0;
            end else begin
               r_shift <= {1'b1, r_shift[UART_FRAME_BITS-1:1]};
               r_bit   <= r_bit + 1'b1;
               r_baud  <= BAUD_W'(BIT_CYC - 1);
            end
         end else begin
            r_baud <= r_baud - 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_uart_sender.sv
// Drains a full ADC capture FIFO as header + data bytes over 8N1 UART.
// Optional trailing checksum byte when FIFO_UART_SENDER_CHECKSUM_EN is defined.
//   state | meaning
//   IDLE  | wait for fifo_full & start_en
//   HDR   | header byte on the line
//   FETCH | read strobe, or end of frame if FIFO empty
//   LATCH | fifo_dout into transmitter
//   SEND  | data byte on the line
//   CSUM  | checksum byte on the line (checksum build only)
//   DONE  | frame_done pulse, back to IDLE
module fifo_uart_sender
   import osc_pkg::*;
#(
   parameter int         CLK_HZ    = 25_000_000,
   parameter int         BAUD      = 115200,
   parameter int         FRAME_LEN = 512,
   parameter logic [7:0] HDR_BYTE  = DEF_HDR_BYTE
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_en,
   input  logic       fifo_full,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_dout,
   output logic       fifo_rd_en,
   output logic       busy,
   output logic       frame_done,
   output logic       frame_short,
   output logic       uart_tx
);

   localparam int BIT_CYC = CLK_HZ / BAUD;
   localparam int CNT_W   = $clog2(FRAME_LEN + 1);
`ifdef FIFO_UART_SENDER_CHECKSUM_EN
   localparam state_t END_ST = CSUM;
`else
   localparam state_t END_ST = DONE;
`endif

   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_short;
   logic             w_load;
   logic [7:0]       w_tx_data;
   logic             w_tx_done;
   logic             w_tx_busy;
   logic             w_last;
`ifdef FIFO_UART_SENDER_CHECKSUM_EN
   logic [7:0]       r_sum;
`endif

   uart_tx_byte #(.BIT_CYC(BIT_CYC)) u_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (w_load),
      .data  (w_tx_data),
      .tx    (uart_tx),
      .done  (w_tx_done),
      .busy  (w_tx_busy)
   );

   assign w_last      = (r_cnt == CNT_W'(FRAME_LEN - 1));
   assign busy        = (r_state != IDLE);
   assign frame_done  = (r_state == DONE);
   assign frame_short = (r_state == DONE) && r_short;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_short <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == DONE)
            r_cnt <= '0;
         else if (r_state == SEND && w_tx_done)
            r_cnt <= r_cnt + 1'b1;
         if (r_state == IDLE || r_state == DONE)
            r_short <= 1'b0;
         else if (r_state == FETCH && fifo_empty)
            r_short <= 1'b1;
      end
   end

`ifdef FIFO_UART_SENDER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_sum <= '0;
      else if (r_state == IDLE)
         r_sum <= '0;
      else if (r_state == LATCH)
         r_sum <= r_sum + fifo_dout;
   end
`endif

   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_tx_data  = HDR_BYTE;
      fifo_rd_en = 1'b0;
      case (r_state)
         IDLE: begin
            if (fifo_full && start_en && !w_tx_busy) begin
               w_next = HDR;
               w_load = 1'b1;
            end
         end
         HDR: if (w_tx_done) w_next = FETCH;
         FETCH: begin
            if (fifo_empty) begin
               w_next = END_ST;
            end else begin
               fifo_rd_en = 1'b1;
               w_next     = LATCH;
            end
         end
         LATCH: begin
            w_load    = 1'b1;
            w_tx_data = fifo_dout;
            w_next    = SEND;
         end
         SEND: if (w_tx_done) w_next = w_last ? END_ST : FETCH;
         CSUM: begin
`ifdef FIFO_UART_SENDER_CHECKSUM_EN
            w_load    = !w_tx_busy;
            w_tx_data = r_sum;
            if (w_tx_done) w_next = DONE;
`else
            w_next = IDLE;
`endif
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fifo_uart_sender.sv
// Bench for fifo_uart_sender: FIFO model, UART decoder and a cycle-level frame timing model.
`timescale 1ns/1ps
module tb_fifo_uart_sender;

   localparam int FL = 4;
   localparam int B  = 217;
`ifdef FIFO_UART_SENDER_CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_en = 1'b0;
   logic       fifo_full = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_dout = 8'h00;
   logic       fifo_rd_en, busy, frame_done, frame_short, uart_tx;

   fifo_uart_sender #(
      .CLK_HZ    (25_000_000),
      .BAUD      (115200),
      .FRAME_LEN (FL),
      .HDR_BYTE  (8'hA5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_en    (start_en),
      .fifo_full   (fifo_full),
      .fifo_empty  (fifo_empty),
      .fifo_dout   (fifo_dout),
      .fifo_rd_en  (fifo_rd_en),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_short (frame_short),
      .uart_tx     (uart_tx)
   );

   always #20 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   // FIFO with one-cycle read latency
   logic [7:0] fifo_q[$];
   always @(posedge clk) begin
      if (fifo_rd_en && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Frame model: byte list and per-byte start offsets from the frame start edge
   bit         m_act = 1'b0;
   int         m_t, m_nd, m_done_t;
   bit         m_short;
   logic [7:0] m_b[$];
   int         m_s[$];

   always @(posedge clk) begin
      if (!rst_n) begin
         m_act = 1'b0;
      end else if (m_act) begin
         m_t++;
         if (m_t > m_done_t) m_act = 1'b0;
      end else if (start_en && fifo_full) begin
         logic [7:0] sum;
         int gap;
         sum = 8'h00;
         m_b.delete();
         m_s.delete();
         m_b.push_back(8'hA5);
         m_short = (fifo_q.size() < FL);
         m_nd    = m_short ? fifo_q.size() : FL;
         for (int i = 0; i < m_nd; i++) begin
            m_b.push_back(fifo_q[i]);
            sum = sum + fifo_q[i];
         end
         if (CS) m_b.push_back(sum);
         m_s.push_back(0);
         for (int k = 1; k < m_b.size(); k++) begin
            gap = (CS && k == m_b.size() - 1 && !m_short) ? 1 : 2;
            m_s.push_back(m_s[k-1] + 10 * B + gap);
         end
         m_done_t = m_s[m_b.size()-1] + 10 * B + ((m_short && !CS) ? 1 : 0);
         m_t      = 0;
         m_act    = 1'b1;
      end
   end

   always @(negedge clk) begin
      logic e_tx, e_busy, e_done, e_short, e_rd;
      logic [7:0] bb;
      int bi;
      e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_short = 1'b0; e_rd = 1'b0;
      if (m_act) begin
         e_busy  = 1'b1;
         e_done  = (m_t == m_done_t);
         e_short = e_done && m_short;
         for (int k = 0; k < m_b.size(); k++) begin
            if (m_t >= m_s[k] && m_t < m_s[k] + 10 * B) begin
               bi = (m_t - m_s[k]) / B;
               bb = m_b[k];
               e_tx = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : bb[bi-1];
            end
            if (k >= 1 && k <= m_nd && m_t == m_s[k] - 2) e_rd = 1'b1;
         end
      end
      chk("uart_tx", uart_tx, e_tx);
      chk("busy", busy, e_busy);
      chk("frame_done", frame_done, e_done);
      chk("frame_short", frame_short, e_short);
      chk("fifo_rd_en", fifo_rd_en, e_rd);
   end

   // UART decoder sampling mid-bit
   logic [7:0] rx_q[$];
   bit         rx_on = 1'b0;
   int         rx_ph;
   logic [7:0] rx_sh;
   always @(negedge clk) begin
      if (!rst_n) begin
         rx_on = 1'b0;
      end else if (!rx_on) begin
         if (!uart_tx) begin rx_on = 1'b1; rx_ph = 0; end
      end else begin
         rx_ph++;
         if (rx_ph % B == B / 2) begin
            if (rx_ph / B == 0) chk("rx_start_bit", uart_tx, 0);
            else if (rx_ph / B <= 8) rx_sh[rx_ph/B-1] = uart_tx;
            else begin
               chk("rx_stop_bit", uart_tx, 1);
               rx_q.push_back(rx_sh);
               rx_on = 1'b0;
            end
         end
      end
   end

   int n_rd = 0, n_done = 0, n_short = 0;
   always @(negedge clk) begin
      if (fifo_rd_en) n_rd++;
      if (frame_done) n_done++;
      if (frame_short) n_short++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic begin_frame(output int hc);
      int i;
      fifo_full = 1'b1;
      for (i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!uart_tx) break;
      end
      chk("start_timeout", int'(i < 20), 1);
      hc = cyc;
   endtask

   task automatic wait_done(output int dc);
      int i;
      for (i = 0; i < 30000; i++) begin
         @(negedge clk);
         if (frame_done) break;
      end
      chk("done_timeout", int'(i < 30000), 1);
      dc = cyc;
      fifo_full = 1'b0;
   endtask

   task automatic cleanup();
      tick(3);
      fifo_q.delete();
      rx_q.delete();
      tick(2);
   endtask

   task automatic chk_rx(input logic [7:0] ex[$]);
      chk("rx_count", rx_q.size(), ex.size());
      for (int i = 0; i < ex.size() && i < rx_q.size(); i++)
         chk($sformatf("rx_byte%0d", i), rx_q[i], ex[i]);
   endtask

   initial begin
      int hc, dc, rd0, dn0, sh0, lat;
      logic [7:0] ex[$];

      tick(3);
      chk("rst_uart_tx", uart_tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_short", frame_short, 0);
      chk("rst_fifo_rd_en", fifo_rd_en, 0);
      rst_n = 1'b1;
      tick(5);

      // full frame
      fifo_q = '{8'h01, 8'h80, 8'hFF, 8'h00};
      start_en = 1'b1;
      tick(2);
      rd0 = n_rd; dn0 = n_done; sh0 = n_short;
      begin_frame(hc);
      wait_done(dc);
      chk("full_duration", dc - hc, CS ? (6 * 10 * B + 4 * 2 + 1) : (5 * 10 * B + 4 * 2));
      ex = '{8'hA5, 8'h01, 8'h80, 8'hFF, 8'h00};
      if (CS) ex.push_back(8'h80);
      chk_rx(ex);
      tick(1);
      chk("full_rd_pulses", n_rd - rd0, 4);
      chk("full_done_pulses", n_done - dn0, 1);
      chk("full_short_pulses", n_short - sh0, 0);
      cleanup();

      // short frame
      fifo_q = '{8'h10, 8'h20, 8'h30};
      tick(2);
      rd0 = n_rd; dn0 = n_done; sh0 = n_short;
      begin_frame(hc);
      wait_done(dc);
      ex = '{8'hA5, 8'h10, 8'h20, 8'h30};
      if (CS) ex.push_back(8'h60);
      chk_rx(ex);
      tick(1);
      chk("short_rd_pulses", n_rd - rd0, 3);
      chk("short_done_pulses", n_done - dn0, 1);
      chk("short_short_pulses", n_short - sh0, 1);
      cleanup();

      // two-byte frame, checksum wraps mod 256
      fifo_q = '{8'hF0, 8'h20};
      tick(2);
      begin_frame(hc);
      wait_done(dc);
      ex = '{8'hA5, 8'hF0, 8'h20};
      if (CS) ex.push_back(8'h10);
      chk_rx(ex);
      cleanup();

      // start_en gating
      start_en = 1'b0;
      fifo_q.push_back(8'($urandom));
      tick(2);
      fifo_full = 1'b1;
      tick(50);
      chk("gated_busy", busy, 0);
      chk("gated_uart_tx", uart_tx, 1);
      start_en = 1'b1;
      for (lat = 0; lat < 10; lat++) begin
         @(negedge clk);
         if (!uart_tx) break;
      end
      chk("start_latency_le2", int'(lat < 2), 1);
      wait_done(dc);
      cleanup();

      // start_en and fifo_full dropped mid-frame
      for (int i = 0; i < FL + 1; i++) fifo_q.push_back(8'($urandom));
      tick(2);
      rd0 = n_rd; dn0 = n_done;
      begin_frame(hc);
      tick(3000);
      start_en  = 1'b0;
      fifo_full = 1'b0;
      wait_done(dc);
      tick(1);
      chk("drop_rd_pulses", n_rd - rd0, FL);
      chk("drop_done_pulses", n_done - dn0, 1);
      chk("drop_rx_count", rx_q.size(), FL + 1 + (CS ? 1 : 0));
      cleanup();
      start_en = 1'b1;

      // random frames
      for (int f = 0; f < 2; f++) begin
         int n;
         n = $urandom_range(1, FL + 1);
         for (int i = 0; i < n; i++) fifo_q.push_back(8'($urandom));
         tick(2);
         begin_frame(hc);
         wait_done(dc);
         cleanup();
      end

      // reset during a data bit
      fifo_q = '{8'h55, 8'hAA, 8'h0F, 8'hF0};
      tick(2);
      begin_frame(hc);
      tick(10 * B + 2 + 500);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_uart_tx", uart_tx, 1);
      chk("midrst_busy", busy, 0);
      @(negedge clk);
      fifo_full = 1'b0;
      fifo_q.delete();
      rx_q.delete();
      tick(2);
      rst_n = 1'b1;
      tick(200);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_rx_count", rx_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/fifo_uart_sender.md
Name: fifo_uart_sender

Overview:
- Reader side of the ADC capture FIFO (adc_fifo); the trigger/writer logic fills that FIFO.
- Waits for a full capture, drains it byte-by-byte and serialises each byte as 8N1 UART to the host PC.
- Each frame is sent as: header byte, then data bytes.
- Runs on the ADC clock domain (25 MHz); asserts busy so the writer side does not refill while draining.

Parameters:
- CLK_HZ, 25_000_000, input clock frequency in Hz.
- BAUD, 115200, UART bit rate; bit period = CLK_HZ/BAUD cycles, integer truncation (217 at defaults).
- FRAME_LEN, 512, maximum data bytes per frame; 1..65535.
- HDR_BYTE, 8'hA5, frame start marker sent before data.

Ports:
- clk  in  1  system clock (adclk domain).
- rst_n  in  1  asynchronous active-low reset.
- start_en  in  1  level; frames are started only while high.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  8  FIFO read data; valid 1 cycle after fifo_rd_en.
- fifo_rd_en  out  1  single-cycle FIFO read strobe.
- busy  out  1  high from frame start until frame_done.
- frame_done  out  1  one-cycle pulse at end of frame.
- frame_short  out  1  one-cycle pulse, coincident with frame_done, when FIFO emptied before FRAME_LEN bytes.
- uart_tx  out  1  serial output, idle high.

Behaviour:
- Reset (async, rst_n=0): uart_tx=1; fifo_rd_en=0; busy=0; frame_done=0; frame_short=0; byte counter=0; FSM=IDLE. Asserting reset mid-byte forces uart_tx=1 immediately.
- FSM states: IDLE, HDR, FETCH, LATCH, SEND, DONE.
- IDLE: when fifo_full & start_en are sampled high, go to HDR and set busy=1 on the same edge.
- HDR: transmit HDR_BYTE; when the byte completes, go to FETCH.
- FETCH:
  - if fifo_empty: go to DONE with short=1.
  - else: fifo_rd_en=1 for exactly one cycle, then go to LATCH.
- LATCH: capture fifo_dout into the tx shift register; go to SEND.
- SEND: transmit the byte; on completion, counter+1.
  - if counter==FRAME_LEN: go to DONE (short=0).
  - else: go to FETCH.
- DONE: frame_done=1 for one cycle; frame_short=short; busy=0 on the next edge; counter cleared; return to IDLE.
- A new frame starts only after another full + start_en sample, at least 1 cycle after DONE.
- UART framing: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly CLK_HZ/BAUD cycles, so one byte is 10 bit periods.
- Byte-to-byte handover:
  - header→first data start bit: FETCH + LATCH add 2 idle-high cycles, so the gap is 2 cycles.
  - consecutive data bytes: same 2-cycle gap.
- start_en falling mid-frame has no effect; the frame completes.
- fifo_full falling mid-frame is ignored; draining depends only on fifo_empty.
- Counter width is $clog2(FRAME_LEN+1); no wrap is possible.

Optional Feature:
- Macro: FIFO_UART_SENDER_CHECKSUM_EN.
- When defined:
  - an 8-bit running sum (mod 256) of all data bytes (header excluded) is kept and cleared at frame start;
  - after the last data byte (full or short frame), state CSUM transmits the sum, then goes to DONE;
  - frame_done fires after the checksum stop bit.
- When undefined: no CSUM state, no adder logic; frame = header + data only.

Decomposition:
- Shared package osc_pkg:
  - FSM state enum (IDLE, HDR, FETCH, LATCH, SEND, CSUM, DONE);
  - UART frame bit count constant (10);
  - default HDR_BYTE.
- One sub-module: uart_tx_byte (inputs: clk, rst_n, load, data[7:0]; outputs: tx, done pulse, busy). It owns the baud counter and shift register. fifo_uart_sender owns FSM, counter and FIFO handshake.

Test Plan:
- Reset mid-byte: drive rst_n=0 during a data bit -> uart_tx=1 and busy=0 asynchronously. After release, nothing is transmitted until fifo_full & start_en.
- Full frame, FRAME_LEN=4, FIFO preloaded 8'h01,8'h80,8'hFF,8'h00, fifo_full=1, start_en=1 -> bench UART decode (217-cycle bits) yields A5,01,80,FF,00. Exactly 4 fifo_rd_en pulses. frame_done once, frame_short=0. Header start bit to final stop bit end = 5*2170+4*2 cycles.
- Short frame: FRAME_LEN=8, FIFO holds 3 bytes (10,20,30) -> output A5,10,20,30. frame_done and frame_short pulse together. No fifo_rd_en while empty.
- start_en=0 with fifo_full=1 -> uart_tx stays 1, busy=0. Raising start_en -> header start bit begins within 2 cycles.
- Checksum (macro defined), data 8'hF0,8'h20 -> output A5,F0,20,10 (sum 0x110 mod 256 = 0x10). frame_done follows the checksum stop bit.
- start_en dropped and fifo_full cleared mid-frame -> frame still completes all FRAME_LEN bytes. busy stays high until frame_done.
